// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file read/write port between NREQ requesters.
// Grants are single-cycle and registered; read data returns one cycle after the read access.
module regfile_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               rf_we,
  output logic [AW-1:0]      rf_addr,
  output logic [DW-1:0]      rf_wdata,
  input  logic [DW-1:0]      rf_rdata,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_addr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic            busy_q;

  logic [NREQ-1:0] cand_s;
  logic            found_s;
  logic            hit_s;
  logic [IW-1:0]   last_d;
  logic [NREQ-1:0] gnt_d;
  logic            rf_we_d;
  logic [AW-1:0]   rf_addr_d;
  logic [DW-1:0]   rf_wdata_d;

  // Candidate set: the requester owning the running access still holds req, so mask it out.
  always_comb begin
    if (state_q == S_ISSUE) begin
      cand_s = req & ~gnt_q;
    end else begin
      cand_s = req;
    end
  end

  // Round-robin search upward from last+1, wrapping modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    last_d  = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      hit_s   = !found_s && cand_s[(int'(last_q) + k) % NREQ];
      last_d  = hit_s ? IW'((int'(last_q) + k) % NREQ) : last_d;
      found_s = found_s | hit_s;
    end
  end

  // Select the winning command for capture at the next edge.
  always_comb begin
    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << last_d;
    rf_we_d    = req_we[last_d];
    rf_addr_d  = req_addr[int'(last_d)*AW +: AW];
    rf_wdata_d = req_wdata[int'(last_d)*DW +: DW];
  end

  // FSM with registered grant, register-file controls and read-data return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(NREQ-1);
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rvalid_q <= '0;
        end
        S_ISSUE: begin
          if (rf_we_q) begin
            rvalid_q <= '0;
          end else begin
            rvalid_q <= gnt_q;
            rdata_q  <= rf_rdata;
          end
        end
        default: begin
          rvalid_q <= '0;
        end
      endcase

      if (found_s) begin
        state_q    <= S_ISSUE;
        busy_q     <= 1'b1;
        last_q     <= last_d;
        gnt_q      <= gnt_d;
        rf_we_q    <= rf_we_d;
        rf_addr_q  <= rf_addr_d;
        rf_wdata_q <= rf_wdata_d;
      end else begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        gnt_q      <= '0;
        rf_we_q    <= 1'b0;
      end
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized requester traffic.
module tb_regfile_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               rf_we;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_wdata;
  logic [DW-1:0]      rf_rdata;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] default_val(input logic [AW-1:0] a);
    return (a == 5'd7) ? 16'hBEEF : (16'hC000 | 16'(a));
  endfunction

  // Register file: unwritten entries read a fixed power-up pattern.
  logic [DW-1:0] rf_mem [32];
  bit            rf_v   [32];
  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_addr] <= rf_wdata;
      rf_v[rf_addr]   <= 1'b1;
    end
  end
  assign rf_rdata = rf_v[rf_addr] ? rf_mem[rf_addr] : default_val(rf_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access per cycle, owner = first requester after last
  // (excluding the one whose access is running), memory updated when a write completes.
  logic [DW-1:0]   gold   [32];
  bit              gold_v [32];
  int              m_cur = -1;
  int              m_last = NREQ-1;
  int              m_w;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wd;
  logic [NREQ-1:0] e_gnt = '0, e_rvalid = '0;
  logic [DW-1:0]   e_rdata = '0, e_rf_wdata = '0;
  logic [AW-1:0]   e_rf_addr = '0;
  logic            e_rf_we = 1'b0, e_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = -1; m_last = NREQ-1;
      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_rf_we = 1'b0;
      e_rf_addr = '0; e_rf_wdata = '0; e_busy = 1'b0;
    end else begin
      e_rvalid = '0;
      if (m_cur >= 0) begin
        if (m_we) begin
          gold[m_addr] = m_wd;
          gold_v[m_addr] = 1'b1;
        end else begin
          e_rvalid[m_cur] = 1'b1;
          e_rdata = gold_v[m_addr] ? gold[m_addr] : default_val(m_addr);
        end
      end
      m_w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (m_w < 0 && req[(m_last + k) % NREQ] && ((m_last + k) % NREQ) != m_cur)
          m_w = (m_last + k) % NREQ;
      end
      e_gnt = '0;
      if (m_w >= 0) begin
        m_cur = m_w; m_last = m_w;
        m_we = req_we[m_w];
        m_addr = req_addr[m_w*AW +: AW];
        m_wd = req_wdata[m_w*DW +: DW];
        e_gnt[m_w] = 1'b1;
        e_rf_we = m_we; e_rf_addr = m_addr; e_rf_wdata = m_wd; e_busy = 1'b1;
      end else begin
        m_cur = -1; e_rf_we = 1'b0; e_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rvalid", 32'(rvalid), 32'(e_rvalid));
    check("rdata", 32'(rdata), 32'(e_rdata));
    check("rf_we", 32'(rf_we), 32'(e_rf_we));
    check("rf_addr", 32'(rf_addr), 32'(e_rf_addr));
    check("rf_wdata", 32'(rf_wdata), 32'(e_rf_wdata));
    check("busy", 32'(busy), 32'(e_busy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic new_cmd(input int i);
    set_cmd(i, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
  endtask

  bit granted_prev [NREQ];

  // Requester behaviour: hold until gnt, then drop or issue a new command.
  task automatic agent_step(input int new_pct, input int wd_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (granted_prev[i]) begin
        granted_prev[i] = 1'b0;
        if ($urandom_range(99) < new_pct) new_cmd(i);
        else req[i] = 1'b0;
      end else if (gnt[i]) begin
        granted_prev[i] = 1'b1;
      end else if (req[i]) begin
        if ($urandom_range(99) < wd_pct) req[i] = 1'b0;
      end else if ($urandom_range(99) < new_pct) begin
        new_cmd(i);
      end
    end
  endtask

  logic [NREQ-1:0] prev_gnt;

  initial begin
    #2 rst = 1'b1;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // Contention from reset: both write.
    set_cmd(0, 1'b1, 5'd0, 16'h1111);
    set_cmd(1, 1'b1, 5'd1, 16'h2222);
    tick();
    check("cont_gnt0", 32'(gnt), 32'h1);
    check("cont_busy0", 32'(busy), 32'h1);
    tick(); req[0] = 1'b0;
    check("cont_gnt1", 32'(gnt), 32'h2);
    check("cont_busy1", 32'(busy), 32'h1);
    tick(); req[1] = 1'b0;
    check("cont_gnt2", 32'(gnt), 32'h0);
    check("cont_busy2", 32'(busy), 32'h0);

    // Read both values back.
    set_cmd(0, 1'b0, 5'd1, 16'h0);
    set_cmd(1, 1'b0, 5'd0, 16'h0);
    tick();
    check("rb_gnt0", 32'(gnt), 32'h1);
    tick(); req[0] = 1'b0;
    check("rb_rvalid0", 32'(rvalid), 32'h1);
    check("rb_rdata0", 32'(rdata), 32'h2222);
    tick(); req[1] = 1'b0;
    check("rb_rvalid1", 32'(rvalid), 32'h2);
    check("rb_rdata1", 32'(rdata), 32'h1111);
    tick();

    // Single read of addr 7 by requester 1.
    set_cmd(1, 1'b0, 5'd7, 16'h0);
    tick();
    check("sr_gnt", 32'(gnt), 32'h2);
    tick(); req[1] = 1'b0;
    check("sr_rvalid", 32'(rvalid), 32'h2);
    check("sr_rdata", 32'(rdata), 32'hBEEF);
    tick();

    // Write then read of the same address across requesters.
    set_cmd(0, 1'b1, 5'd5, 16'hA5A5);
    set_cmd(1, 1'b0, 5'd5, 16'h0);
    tick();
    check("raw_gnt0", 32'(gnt), 32'h1);
    tick(); req[0] = 1'b0;
    check("raw_gnt1", 32'(gnt), 32'h2);
    tick(); req[1] = 1'b0;
    check("raw_rvalid", 32'(rvalid), 32'h2);
    check("raw_rdata", 32'(rdata), 32'hA5A5);
    tick();

    // Withdrawn request: req[1] pulses between edges during r0's access.
    set_cmd(0, 1'b0, 5'd2, 16'h0);
    tick();
    check("wd_gnt0", 32'(gnt), 32'h1);
    #1 set_cmd(1, 1'b1, 5'd9, 16'h9999);
    #1 req[1] = 1'b0;
    tick(); req[0] = 1'b0;
    check("wd_gnt1", 32'(gnt), 32'h0);
    check("wd_busy1", 32'(busy), 32'h0);
    tick();
    check("wd_gnt2", 32'(gnt), 32'h0);
    check("wd_busy2", 32'(busy), 32'h0);

    // Fairness: both keep requesting; grants must alternate every cycle.
    agent_step(100, 0);
    tick();
    prev_gnt = gnt;
    check("fair_first", 32'(gnt != '0), 32'h1);
    for (int c = 0; c < 20; c++) begin
      agent_step(100, 0);
      tick();
      check("fair_alt", 32'(gnt != '0 && gnt != prev_gnt), 32'h1);
      prev_gnt = gnt;
    end
    req = '0;
    for (int i = 0; i < NREQ; i++) granted_prev[i] = 1'b0;
    repeat (3) tick();

    // Reset during a write ISSUE to addr 3.
    set_cmd(0, 1'b1, 5'd3, 16'h3333);
    tick();
    check("mr_gnt", 32'(gnt), 32'h1);
    check("mr_we", 32'(rf_we), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mr_gnt_rst", 32'(gnt), 32'h0);
    check("mr_we_rst", 32'(rf_we), 32'h0);
    check("mr_rvalid_rst", 32'(rvalid), 32'h0);
    req = '0;
    tick();
    #2 rst = 1'b0;
    tick();
    set_cmd(0, 1'b0, 5'd3, 16'h0);
    set_cmd(1, 1'b0, 5'd3, 16'h0);
    tick();
    check("mr_first_gnt", 32'(gnt), 32'h1);
    tick(); req[0] = 1'b0;
    check("mr_rvalid", 32'(rvalid), 32'h1);
    check("mr_addr3", 32'(rdata), 32'hC003);
    tick(); req[1] = 1'b0;
    repeat (2) tick();

    // Randomized traffic with occasional withdrawals.
    for (int c = 0; c < 3000; c++) begin
      agent_step(40, 5);
      tick();
    end
    req = '0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-write/single-read port of the 32x16 register file between several requesters: the operation-sequencing FSM, the scan/display walker, and a debug port. Each requester posts a read or write command with a level request and receives a one-cycle grant. Read data comes back on a shared bus with a per-requester valid. Grant order is round-robin, so the scan walker cannot starve operand/result writes and vice versa.

## Interface
- NREQ, 2: number of requesters. Legal range is 2..4.
- AW, 5: register file address width.
- DW, 16: register file data width.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request level, one bit per requester.
- req_we  in  NREQ  1 means write, 0 means read.
- req_addr  in  NREQ*AW  address for requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  write data for requester i at [i*DW +: DW].
- gnt  out  NREQ  one-hot, registered, single-cycle grant.
- rvalid  out  NREQ  one-hot, single-cycle read-data valid.
- rdata  out  DW  shared read data; meaningful only while some rvalid bit is high.
- rf_we  out  1  register file write enable.
- rf_addr  out  AW  register file address, used for both read and write.
- rf_wdata  out  DW  register file write data.
- rf_rdata  in  DW  register file combinational read of rf_addr.
- busy  out  1  high while in ISSUE.

## Operation
- **Requester contract:** hold req, req_we, req_addr and req_wdata stable until gnt is seen high. Drop req, or present a new command, on the cycle after gnt.
- **States:**
  - IDLE: no access in progress.
  - ISSUE: one register file access in progress; gnt is high for the winner.
- **Arbitration:** round-robin.
  - The winner is the first i with req[i]=1, searching upward from last+1 and wrapping modulo NREQ.
  - last is the index of the most recent winner.
- **IDLE:**
  - If any req bit is set, pick the winner.
  - At the edge, register gnt=onehot(winner), rf_we=req_we[w], rf_addr=req_addr[w], rf_wdata=req_wdata[w]; update last=w; go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - The access executes: a write commits at the ending edge, and a read samples rf_rdata into rdata at the ending edge.
  - The current winner is excluded from arbitration this cycle, because its req is still high.
  - If another requester is pending, re-arbitrate and go to ISSUE again back-to-back.
  - Otherwise go to IDLE.
- **rvalid[w]** is high in the cycle after a read ISSUE. rvalid stays 0 after a write.
- **Outside ISSUE:**
  - gnt=0 and rf_we=0.
  - rf_addr and rf_wdata hold their last value.
  - rdata holds until the next read.
- **Consistency:** a command is captured only at the edge where it wins. A req dropped before that edge is never granted, and no partial access occurs.
- **Write-then-read of the same address** from different requesters in back-to-back ISSUE cycles returns the new data, since the register file writes at the first edge.

## Timing
- **Reset values (asynchronous, immediate):**
  - State = IDLE; last = NREQ-1, so requester 0 wins first.
  - gnt=0, rvalid=0, rdata=0, rf_we=0, rf_addr=0, rf_wdata=0, busy=0.
- **Latency:**
  - req sampled high at edge k → gnt and rf_* valid in cycle k..k+1 → rvalid and rdata valid in cycle k+1..k+2.
  - Request-to-data latency is 2 cycles.
- **Throughput:**
  - Alternating requesters get one access per cycle.
  - A single requester gets one access per 2 cycles, because of its mandatory req drop after gnt.
- **Simultaneous requests:** resolved purely by round-robin from last. Ties are impossible.
- **Reset asserted during ISSUE:** rf_we drops immediately. No write occurs unless rst deasserts before the edge. The pending rvalid is cancelled.
- **Index wrap-around:** from last=NREQ-1 the search starts at 0.

## Test plan
- **Reset:** assert rst mid-ISSUE of a write to addr 3 → gnt, rf_we and rvalid read 0 within the same cycle; addr 3 is unchanged; the first grant after release goes to requester 0.
- **Single read:** NREQ=2, requester 1 reads addr 7 holding 0xBEEF → gnt=2'b10 one cycle after req is sampled, rvalid=2'b10 and rdata=0xBEEF on the next cycle.
- **Contention:** both requesters request from reset, both writing (r0 addr 0 ← 0x1111, r1 addr 1 ← 0x2222) → gnt sequence 01, 10 back-to-back with busy high for 2 cycles; both values are later read back.
- **Fairness:** both requesters hold req continuously, re-requesting the cycle after each grant, for 20 cycles → grants strictly alternate and neither requester waits more than 2 cycles.
- **RAW across requesters:** r0 writes addr 5 ← 0xA5A5 in the same cycle r1 requests a read of addr 5 → r1's rdata=0xA5A5.
- **Withdrawn request:** req[1] pulses for a cycle with no sampling edge while in ISSUE for r0, then r0 drops → no gnt[1]; return to IDLE with busy=0.
